// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and width helpers for the sequential
// binary-to-BCD converter.
//   b2b_state_t     : converter FSM states
//   bcd_width(w)    : BCD result width for a w-bit binary input
//   bcd_digits(w)   : number of 4-bit digits needed to hold that result
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} b2b_state_t;

  function automatic int bcd_width(input int w);
    return w + (w - 4) / 3 + 1;
  endfunction

  function automatic int bcd_digits(input int w);
    return (bcd_width(w) + 3) / 4;
  endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// bin2bcd_step: one combinational double-dabble iteration.
//   i_acc [ND*4-1:0] : BCD accumulator before this step
//   i_bit            : next binary bit (MSB first) shifted into digit 0
//   o_acc [ND*4-1:0] : accumulator after add-3 correction and left shift
module bin2bcd_step #(
  parameter int ND = 3
) (
  input  logic [ND*4-1:0] i_acc,
  input  logic            i_bit,
  output logic [ND*4-1:0] o_acc
);

  logic [ND*4-1:0] w_adj;

  // Every digit is corrected from its current value before the shift,
  // so no digit sees a carry from its lower neighbour's correction.
  for (genvar k = 0; k < ND; k++) begin : g_dig
    assign w_adj[k*4 +: 4] = (i_acc[k*4 +: 4] > 4'd4) ? i_acc[k*4 +: 4] + 4'd3
                                                       : i_acc[k*4 +: 4];
  end

  // The top bit shifted out is always zero for legal input widths.
  assign o_acc = (w_adj << 1) | {{(ND*4-1){1'b0}}, i_bit};

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle binary-to-BCD converter, one bit per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, bin [W-1:0] accepted in IDLE
//   out_valid / out_ready: output handshake, bcd [BW-1:0] held until taken
//   busy                 : high while converting or holding a result
//   blank [ND-1:0]       : leading-zero digit flags, only when the macro
//                          BIN2BCD_SEQ_BLANK_EN is defined
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter  int W  = 8,
  localparam int BW = bcd_width(W),
  localparam int ND = bcd_digits(W),
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] bcd,
`ifdef BIN2BCD_SEQ_BLANK_EN
  output logic [ND-1:0] blank,
`endif
  output logic          busy
);

  b2b_state_t      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_shreg;
  logic [ND*4-1:0] r_acc;
  logic [ND*4-1:0] w_acc_nxt;

  bin2bcd_step #(.ND(ND)) u_step (
    .i_acc (r_acc),
    .i_bit (r_shreg[W-1]),
    .o_acc (w_acc_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)      w_state_nxt = CONV;
      CONV:    if (r_cnt == '0)   w_state_nxt = DONE;
      DONE:    if (out_ready)     w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (in_valid) begin
          r_shreg <= bin;
          r_acc   <= '0;
          r_cnt   <= CW'(W - 1);
        end
        CONV: begin
          r_acc   <= w_acc_nxt;
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIN2BCD_SEQ_BLANK_EN
  logic [ND-1:0] r_blank, w_blank;

  // Walk from the top digit down; a digit is blank while it and every
  // digit above it are zero. Digit 0 always shows.
  always_comb begin : blk_blank
    logic v_zero;
    w_blank = '0;
    v_zero  = 1'b1;
    for (int k = ND - 1; k >= 1; k--) begin
      v_zero     = v_zero & (w_acc_nxt[k*4 +: 4] == 4'd0);
      w_blank[k] = v_zero;
    end
  end

  // Captured on the final conversion edge so it lines up with bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_blank <= '0;
    else if (r_state == CONV && r_cnt == '0)  r_blank <= w_blank;
  end

  assign blank = r_blank;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign bcd       = r_acc[BW-1:0];

endmodule
